// File: rtl/memory_arbiter_pkg.sv
// Shared types for the instruction/data memory arbiter.
// Holds the RAM handshake encoding, the arbiter FSM encoding and the
// capture-register layout used by memory_arbiter.
package memory_arbiter_pkg;

  // RAM controller handshake state as reported on ramstate.
  typedef enum logic [1:0] {
    FREE   = 2'd0,
    BUSY   = 2'd1,
    ACCESS = 2'd2,
    ERROR  = 2'd3
  } ramstate_t;

  // Arbiter FSM: idle, serving a fetch, or serving a data access.
  typedef enum logic [1:0] {
    IDLE = 2'd0,
    IACC = 2'd1,
    DACC = 2'd2
  } arb_state_t;

  localparam int unsigned WORD_W         = 32;
  localparam int unsigned ARB_STARVE_MAX = 4;
  localparam int unsigned ARB_CNT_W      = 3;

  // Everything the RAM needs about the granted request, frozen on the grant edge.
  typedef struct packed {
    logic [WORD_W-1:0] addr;
    logic [WORD_W-1:0] store;
    logic              is_write;
  } capture_t;

  localparam capture_t CAPTURE_RST = '{addr: 32'h0, store: 32'h0, is_write: 1'b0};

  // A data-side request is pending when either strobe is raised.
  function automatic logic data_request(input logic dren, input logic dwen);
    return dren | dwen;
  endfunction

  // Capture image for a data grant; a simultaneous read+write is a write.
  function automatic capture_t capture_data(input logic [WORD_W-1:0] addr,
                                            input logic [WORD_W-1:0] store,
                                            input logic              dwen);
    capture_t c;
    c.addr     = addr;
    c.store    = store;
    c.is_write = dwen;
    return c;
  endfunction

  // Capture image for a fetch grant; fetches never write.
  function automatic capture_t capture_fetch(input logic [WORD_W-1:0] addr);
    capture_t c;
    c.addr     = addr;
    c.store    = 32'h0;
    c.is_write = 1'b0;
    return c;
  endfunction

endpackage

// File: rtl/memory_arbiter_starve_ctr.sv
// Saturating starvation counter for the fetch port.
// Counts data grants taken while a fetch waits; sat tells the arbiter
// that the fetch must win the next grant.
module arb_starve_ctr #(
  parameter int unsigned STARVE_MAX = 4,
  parameter int unsigned CNT_W      = 3
) (
  input  logic CLK,
  input  logic nRST,
  input  logic inc,
  input  logic clr,
  output logic sat
);

  localparam logic [CNT_W-1:0] MAX_C = CNT_W'(STARVE_MAX);
  localparam logic [CNT_W-1:0] ONE_C = CNT_W'(1);

  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             sat_q, sat_d;

  // Next count: clear wins over increment, increment stops at the ceiling.
  always_comb begin
    cnt_d = cnt_q;
    if (clr) begin
      cnt_d = '0;
    end else if (inc && (cnt_q != MAX_C)) begin
      cnt_d = cnt_q + ONE_C;
    end else begin
      cnt_d = cnt_q;
    end
    sat_d = (cnt_d == MAX_C);
  end

  // Count and saturation flag registers.
  always_ff @(posedge CLK or negedge nRST) begin
    if (!nRST) begin
      cnt_q <= '0;
      sat_q <= 1'b0;
    end else begin
      cnt_q <= cnt_d;
      sat_q <= sat_d;
    end
  end

  assign sat = sat_q;

endmodule

// File: rtl/memory_arbiter.sv
// memory_arbiter: shares one single-port RAM between instruction fetch and
// data access. Data has priority; a starvation counter forces a fetch after
// STARVE_MAX consecutive data grants taken while the fetch waits.
// One transaction in flight; the granted request is captured and replayed
// to the RAM until it reports ACCESS.
module memory_arbiter
  import memory_arbiter_pkg::*;
#(
  parameter int unsigned STARVE_MAX = ARB_STARVE_MAX,
  parameter int unsigned CNT_W      = ARB_CNT_W
) (
  input  logic        CLK,
  input  logic        nRST,
  input  logic        iREN,
  input  logic [31:0] iaddr,
  output logic [31:0] iload,
  output logic        ihit,
  input  logic        dREN,
  input  logic        dWEN,
  input  logic [31:0] daddr,
  input  logic [31:0] dstore,
  output logic [31:0] dload,
  output logic        dhit,
  output logic        ramREN,
  output logic        ramWEN,
  output logic [31:0] ramaddr,
  output logic [31:0] ramstore,
  input  logic [31:0] ramload,
  input  logic [1:0]  ramstate
);

  arb_state_t state_q, state_d;
  capture_t   cap_q, cap_d;

  ramstate_t  ram_st;
  logic       ram_access;
  logic       d_req;
  logic       forced_fetch;
  logic       grant_i;
  logic       grant_d;
  logic       starve_sat;
  logic       ctr_inc;
  logic       ctr_clr;

  assign ram_st       = ramstate_t'(ramstate);
  assign ram_access   = (ram_st == ACCESS);
  assign d_req        = data_request(dREN, dWEN);
  assign forced_fetch = iREN & starve_sat;

  // Starvation counter: bumped by data grants that bypass a waiting fetch.
  arb_starve_ctr #(
    .STARVE_MAX (STARVE_MAX),
    .CNT_W      (CNT_W)
  ) u_starve_ctr (
    .CLK  (CLK),
    .nRST (nRST),
    .inc  (ctr_inc),
    .clr  (ctr_clr),
    .sat  (starve_sat)
  );

  // FSM state and capture registers; reset drops any transaction at once.
  always_ff @(posedge CLK or negedge nRST) begin
    if (!nRST) begin
      state_q <= IDLE;
      cap_q   <= CAPTURE_RST;
    end else begin
      state_q <= state_d;
      cap_q   <= cap_d;
    end
  end

  // Next state and grant decision; grants only happen from IDLE.
  always_comb begin
    state_d = state_q;
    grant_i = 1'b0;
    grant_d = 1'b0;
    case (state_q)
      IDLE: begin
        if (forced_fetch) begin
          grant_i = 1'b1;
          state_d = IACC;
        end else if (d_req) begin
          grant_d = 1'b1;
          state_d = DACC;
        end else if (iREN) begin
          grant_i = 1'b1;
          state_d = IACC;
        end else begin
          state_d = IDLE;
        end
      end
      IACC, DACC: begin
        // FREE/BUSY wait, ERROR replays the captured request, ACCESS ends it.
        if (ram_access) begin
          state_d = IDLE;
        end else begin
          state_d = state_q;
        end
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  // Capture the winning request on its grant edge, otherwise hold.
  always_comb begin
    cap_d = cap_q;
    if (grant_d) begin
      cap_d = capture_data(daddr, dstore, dWEN);
    end else if (grant_i) begin
      cap_d = capture_fetch(iaddr);
    end else begin
      cap_d = cap_q;
    end
  end

  // Starvation bookkeeping: count bypassing data grants, clear once fetch is served or idle.
  always_comb begin
    ctr_inc = grant_d & iREN;
    ctr_clr = grant_i | ((state_q == IDLE) & ~iREN);
  end

  // Strobes from the FSM state; hits and load data only in the ACCESS cycle
  // and only while the requester still holds its request.
  always_comb begin
    ramREN = 1'b0;
    ramWEN = 1'b0;
    ihit   = 1'b0;
    dhit   = 1'b0;
    iload  = 32'h0;
    dload  = 32'h0;
    case (state_q)
      IACC: begin
        ramREN = 1'b1;
        if (ram_access && iREN) begin
          ihit  = 1'b1;
          iload = ramload;
        end else begin
          ihit  = 1'b0;
          iload = 32'h0;
        end
      end
      DACC: begin
        ramREN = ~cap_q.is_write;
        ramWEN = cap_q.is_write;
        if (ram_access && d_req) begin
          dhit  = 1'b1;
          dload = ramload;
        end else begin
          dhit  = 1'b0;
          dload = 32'h0;
        end
      end
      default: begin
        ramREN = 1'b0;
        ramWEN = 1'b0;
      end
    endcase
  end

  assign ramaddr  = cap_q.addr;
  assign ramstore = cap_q.store;

endmodule

// File: tb/tb_memory_arbiter.sv
// Directed, table-driven bench for memory_arbiter plus hand sequences for
// starvation and asynchronous reset.
module tb_memory_arbiter;

  localparam logic [1:0] RS_FREE   = 2'd0;
  localparam logic [1:0] RS_BUSY   = 2'd1;
  localparam logic [1:0] RS_ACCESS = 2'd2;
  localparam logic [1:0] RS_ERROR  = 2'd3;
  localparam logic       H = 1'b1;
  localparam logic       L = 1'b0;
  localparam logic [31:0] Z = 32'h0;
  localparam int NV = 25;

  logic        CLK;
  logic        nRST;
  logic        iREN;
  logic [31:0] iaddr;
  logic [31:0] iload;
  logic        ihit;
  logic        dREN;
  logic        dWEN;
  logic [31:0] daddr;
  logic [31:0] dstore;
  logic [31:0] dload;
  logic        dhit;
  logic        ramREN;
  logic        ramWEN;
  logic [31:0] ramaddr;
  logic [31:0] ramstore;
  logic [31:0] ramload;
  logic [1:0]  ramstate;

  int checks;
  int errors;

  typedef struct {
    logic        iren, dren, dwen;
    logic [1:0]  rs;
    logic [31:0] ia, da, ds, rl;
    logic        e_ren, e_wen, e_ihit, e_dhit;
    logic [31:0] e_addr, e_store, e_iload, e_dload;
  } vec_t;

  vec_t vecs [0:NV-1];

  memory_arbiter dut (
    .CLK      (CLK),
    .nRST     (nRST),
    .iREN     (iREN),
    .iaddr    (iaddr),
    .iload    (iload),
    .ihit     (ihit),
    .dREN     (dREN),
    .dWEN     (dWEN),
    .daddr    (daddr),
    .dstore   (dstore),
    .dload    (dload),
    .dhit     (dhit),
    .ramREN   (ramREN),
    .ramWEN   (ramWEN),
    .ramaddr  (ramaddr),
    .ramstore (ramstore),
    .ramload  (ramload),
    .ramstate (ramstate)
  );

  initial CLK = 1'b0;
  always #5 CLK = ~CLK;

  function automatic logic [131:0] outs();
    return {ramREN, ramWEN, ihit, dhit, ramaddr, ramstore, iload, dload};
  endfunction

  task automatic chk_vec(input string nm, input logic [131:0] act, input logic [131:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got ren=%b wen=%b ihit=%b dhit=%b addr=%h store=%h iload=%h dload=%h | want ren=%b wen=%b ihit=%b dhit=%b addr=%h store=%h iload=%h dload=%h",
               nm, act[131], act[130], act[129], act[128], act[127:96], act[95:64], act[63:32], act[31:0],
               exp[131], exp[130], exp[129], exp[128], exp[127:96], exp[95:64], exp[63:32], exp[31:0]);
    end
  endtask

  task automatic chk32(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h want %h", nm, act, exp);
    end
  endtask

  initial begin
    int          dcount;
    logic        ihit_seen;
    logic        overlap;
    logic [31:0] addr_at_hit;
    logic [31:0] iload_at_hit;

    checks = 0;
    errors = 0;
    nRST = 1'b0; iREN = 1'b0; dREN = 1'b0; dWEN = 1'b0;
    iaddr = Z; daddr = Z; dstore = Z; ramload = Z; ramstate = RS_FREE;

    // Rows: inputs for one cycle, then the outputs expected in that same cycle.
    // Fetch only, ACCESS on the second strobe cycle.
    vecs[0]  = '{H,L,L,RS_FREE,  32'h40,Z,Z,Z,                 L,L,L,L, Z,Z,Z,Z};
    vecs[1]  = '{H,L,L,RS_FREE,  32'h40,Z,Z,Z,                 H,L,L,L, 32'h40,Z,Z,Z};
    vecs[2]  = '{H,L,L,RS_ACCESS,32'h40,Z,Z,32'h8C220004,      H,L,H,L, 32'h40,Z,32'h8C220004,Z};
    vecs[3]  = '{L,L,L,RS_FREE,  32'h40,Z,Z,32'h8C220004,      L,L,L,L, 32'h40,Z,Z,Z};
    // Simultaneous fetch and data read: data first, then fetch.
    vecs[4]  = '{H,H,L,RS_FREE,  32'h44,32'h100,Z,Z,           L,L,L,L, 32'h40,Z,Z,Z};
    vecs[5]  = '{H,H,L,RS_ACCESS,32'h44,32'h100,Z,32'h11111111,H,L,L,H, 32'h100,Z,Z,32'h11111111};
    vecs[6]  = '{H,L,L,RS_FREE,  32'h44,32'h100,Z,32'h11111111,L,L,L,L, 32'h100,Z,Z,Z};
    vecs[7]  = '{H,L,L,RS_ACCESS,32'h44,32'h100,Z,32'h22222222,H,L,H,L, 32'h44,Z,32'h22222222,Z};
    vecs[8]  = '{L,L,L,RS_FREE,  32'h44,32'h100,Z,32'h22222222,L,L,L,L, 32'h44,Z,Z,Z};
    // Write with three BUSY cycles.
    vecs[9]  = '{L,L,H,RS_FREE,  Z,32'h200,32'hDEADBEEF,Z,     L,L,L,L, 32'h44,Z,Z,Z};
    vecs[10] = '{L,L,H,RS_BUSY,  Z,32'h200,32'hDEADBEEF,Z,     L,H,L,L, 32'h200,32'hDEADBEEF,Z,Z};
    vecs[11] = '{L,L,H,RS_BUSY,  Z,32'h200,32'hDEADBEEF,Z,     L,H,L,L, 32'h200,32'hDEADBEEF,Z,Z};
    vecs[12] = '{L,L,H,RS_BUSY,  Z,32'h200,32'hDEADBEEF,Z,     L,H,L,L, 32'h200,32'hDEADBEEF,Z,Z};
    vecs[13] = '{L,L,H,RS_ACCESS,Z,32'h200,32'hDEADBEEF,Z,     L,H,L,H, 32'h200,32'hDEADBEEF,Z,Z};
    vecs[14] = '{L,L,L,RS_FREE,  Z,32'h200,32'hDEADBEEF,Z,     L,L,L,L, 32'h200,32'hDEADBEEF,Z,Z};
    // Read that sees ERROR, then BUSY, then ACCESS.
    vecs[15] = '{L,H,L,RS_FREE,  Z,32'h300,Z,Z,                L,L,L,L, 32'h200,32'hDEADBEEF,Z,Z};
    vecs[16] = '{L,H,L,RS_ERROR, Z,32'h300,Z,32'h33333333,     H,L,L,L, 32'h300,Z,Z,Z};
    vecs[17] = '{L,H,L,RS_BUSY,  Z,32'h300,Z,Z,                H,L,L,L, 32'h300,Z,Z,Z};
    vecs[18] = '{L,H,L,RS_ACCESS,Z,32'h300,Z,32'h44444444,     H,L,L,H, 32'h300,Z,Z,32'h44444444};
    vecs[19] = '{L,L,L,RS_FREE,  Z,32'h300,Z,32'h44444444,     L,L,L,L, 32'h300,Z,Z,Z};
    // Fetch withdrawn mid-access: transaction completes, no hit.
    vecs[20] = '{H,L,L,RS_FREE,  32'h48,Z,Z,Z,                 L,L,L,L, 32'h300,Z,Z,Z};
    vecs[21] = '{L,L,L,RS_BUSY,  32'h48,Z,Z,Z,                 H,L,L,L, 32'h48,Z,Z,Z};
    vecs[22] = '{L,L,L,RS_ACCESS,32'h48,Z,Z,32'h55555555,      H,L,L,L, 32'h48,Z,Z,Z};
    vecs[23] = '{L,L,L,RS_FREE,  32'h48,Z,Z,32'h55555555,      L,L,L,L, 32'h48,Z,Z,Z};
    vecs[24] = '{L,L,L,RS_ACCESS,32'h48,Z,Z,32'h55555555,      L,L,L,L, 32'h48,Z,Z,Z};

    // Reset state.
    #12;
    chk_vec("reset", outs(), 132'h0);
    #1;
    nRST = 1'b1;

    // Table-driven cycles.
    for (int k = 0; k < NV; k++) begin
      @(posedge CLK);
      #1;
      iREN = vecs[k].iren; dREN = vecs[k].dren; dWEN = vecs[k].dwen;
      ramstate = vecs[k].rs; iaddr = vecs[k].ia; daddr = vecs[k].da;
      dstore = vecs[k].ds; ramload = vecs[k].rl;
      @(negedge CLK);
      chk_vec($sformatf("vec%0d", k), outs(),
              {vecs[k].e_ren, vecs[k].e_wen, vecs[k].e_ihit, vecs[k].e_dhit,
               vecs[k].e_addr, vecs[k].e_store, vecs[k].e_iload, vecs[k].e_dload});
    end

    // Starvation: data re-requested continuously while fetch waits.
    @(posedge CLK);
    #1;
    iREN = 1'b1; dREN = 1'b1; dWEN = 1'b0; iaddr = 32'h80; daddr = 32'h180;
    dstore = Z; ramstate = RS_ACCESS; ramload = 32'h66;
    dcount = 0; ihit_seen = 1'b0; overlap = 1'b0; addr_at_hit = Z; iload_at_hit = Z;
    for (int c = 0; c < 40 && !ihit_seen; c++) begin
      @(negedge CLK);
      if (ihit && dhit) overlap = 1'b1;
      if (dhit) dcount++;
      if (ihit) begin
        ihit_seen    = 1'b1;
        addr_at_hit  = ramaddr;
        iload_at_hit = iload;
      end
    end
    chk32("starve_dhits", dcount, 32'd4);
    chk32("starve_ihit_seen", {31'b0, ihit_seen}, 32'd1);
    chk32("starve_fetch_addr", addr_at_hit, 32'h80);
    chk32("starve_iload", iload_at_hit, 32'h66);
    chk32("starve_no_overlap", {31'b0, overlap}, 32'd0);
    @(posedge CLK);
    #1;
    iREN = 1'b0; dREN = 1'b0; ramstate = RS_FREE; ramload = Z;

    // Asynchronous reset in the middle of a data access.
    @(posedge CLK);
    #1;
    dREN = 1'b1; daddr = 32'h400; ramstate = RS_BUSY;
    @(posedge CLK);
    #1;
    chk32("rst_pre_ren", {31'b0, ramREN}, 32'd1);
    chk32("rst_pre_addr", ramaddr, 32'h400);
    ramstate = RS_ACCESS; ramload = 32'h77;
    #1;
    chk32("rst_pre_dhit", {31'b0, dhit}, 32'd1);
    #1;
    nRST = 1'b0;
    #1;
    chk_vec("rst_async", outs(), 132'h0);
    dREN = 1'b0; ramstate = RS_FREE;
    @(negedge CLK);
    nRST = 1'b1;
    @(posedge CLK);
    @(negedge CLK);
    chk_vec("post_rst_idle", outs(), 132'h0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
